// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Two-requester (pipeline MEM stage / MemPix stage) arbiter for a
//            single shared memory port.
//            - Round-robin on simultaneous requests; data wins the first tie
//              after reset.
//            - One ISSUE cycle, MEM_LAT WAIT cycles and one DONE cycle per
//              access.
//            - Optional grant counters are enabled by defining ARB_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int MEM_LAT = 2              // read latency after mem_en, 1..4
) (
    input  logic        clk,
    input  logic        reset,             // synchronous, active-low
    input  logic        halt,
    input  logic        dreq,
    input  logic        dwe,
    input  logic [31:0] daddr,
    input  logic [31:0] dwdata,
    input  logic        preq,
    input  logic        pwe,
    input  logic [31:0] paddr,
    input  logic [31:0] pwdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        ddone,
    output logic        pdone,
    output logic [31:0] rdata,
    output logic        stall,
    output logic [15:0] dcount,
    output logic [15:0] pcount
);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_ISSUE = 2'd1;
    localparam logic [1:0] c_ST_WAIT  = 2'd2;
    localparam logic [1:0] c_ST_DONE  = 2'd3;

    // WAIT counts down from MEM_LAT-1 to 0, so it lasts exactly MEM_LAT cycles
    localparam logic [2:0] c_WAIT_INIT = 3'(MEM_LAT - 1);

    logic [1:0]  r_state;
    logic [2:0]  r_wait_cnt;
    logic        r_sel_pix;      // winner of the access in flight (1 = pixel)
    logic        r_last_pix;     // last requester served (1 = pixel)
    logic        r_mem_en;
    logic        r_mem_we;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;
    logic [31:0] r_rdata;
    logic        r_ddone;
    logic        r_pdone;

    logic        w_grant;
    logic        w_pick_pix;

    // A grant is evaluated only in IDLE and only while not halted
    assign w_grant    = (r_state == c_ST_IDLE) && !halt && (dreq || preq);
    // Pixel wins alone, or on a tie when it was not the last one served
    assign w_pick_pix = preq && (!dreq || !r_last_pix);

    // Arbitration FSM with registered memory-port and completion outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= c_ST_IDLE;
            r_wait_cnt  <= 3'd0;
            r_sel_pix   <= 1'b0;
            r_last_pix  <= 1'b1;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= 32'd0;
            r_mem_wdata <= 32'd0;
            r_rdata     <= 32'd0;
            r_ddone     <= 1'b0;
            r_pdone     <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_grant) begin
                        r_state     <= c_ST_ISSUE;
                        r_sel_pix   <= w_pick_pix;
                        r_mem_en    <= 1'b1;
                        r_mem_we    <= w_pick_pix ? pwe    : dwe;
                        r_mem_addr  <= w_pick_pix ? paddr  : daddr;
                        r_mem_wdata <= w_pick_pix ? pwdata : dwdata;
                    end
                end
                c_ST_ISSUE: begin
                    // address/data are left holding their last values
                    r_state    <= c_ST_WAIT;
                    r_mem_en   <= 1'b0;
                    r_mem_we   <= 1'b0;
                    r_wait_cnt <= c_WAIT_INIT;
                end
                c_ST_WAIT: begin
                    if (r_wait_cnt == 3'd0) begin
                        // read data is captured for writes too
                        r_rdata <= mem_rdata;
                        r_ddone <= !r_sel_pix;
                        r_pdone <= r_sel_pix;
                        r_state <= c_ST_DONE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt - 3'd1;
                    end
                end
                c_ST_DONE: begin
                    // no grant from here: next evaluation happens in IDLE
                    r_ddone    <= 1'b0;
                    r_pdone    <= 1'b0;
                    r_last_pix <= r_sel_pix;
                    r_state    <= c_ST_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

`ifdef ARB_STATS_EN
    logic [15:0] r_dcount;
    logic [15:0] r_pcount;

    // Completed-access counters, wrapping at 16 bits
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_dcount <= 16'd0;
            r_pcount <= 16'd0;
        end else begin
            if (r_ddone) r_dcount <= r_dcount + 16'd1;
            if (r_pdone) r_pcount <= r_pcount + 16'd1;
        end
    end

    assign dcount = r_dcount;
    assign pcount = r_pcount;
`else
    assign dcount = 16'd0;
    assign pcount = 16'd0;
`endif

    assign mem_en    = r_mem_en;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign rdata     = r_rdata;
    assign ddone     = r_ddone;
    assign pdone     = r_pdone;
    assign stall     = (dreq | preq) & ~(r_ddone | r_pdone);

endmodule
`default_nettype wire
